fetch_sequencer: RTL

//  Program-counter and fetch controller for the sCPU 16-entry instruction memory.
//  - Drives the memory select (pc_sel) and samples the combinational instruction

---
 rtl/fetch_sequencer_if.sv | 34 +++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus between the fetch sequencer, the instruction memory and decode.
//
// Handshake: decode sees an instruction when ir_valid is high and takes it on a
// rising edge where ir_ready is also high. While ir_valid && !ir_ready, the
// signals ir, ir_pc and ir_valid hold their values. A branch_valid pulse in
// RUN/DRAIN flushes the IR on that edge. If ir_ready is high on the same edge,
// the instruction still does not count as accepted.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic               start;
  logic [ADDR_W-1:0]  pc_sel;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               ir_ready;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               running;
  logic               halted;
  logic [1:0]         state;      // debug view of the sequencer FSM

  modport master (
    input  start, imem_instr, ir_ready, branch_valid, branch_target,
    output pc_sel, ir, ir_pc, ir_valid, running, halted, state
  );

  modport slave (
    output start, imem_instr, ir_ready, branch_valid, branch_target,
    input  pc_sel, ir, ir_pc, ir_valid, running, halted, state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for a small instruction memory.
// The block fetches into a one-entry instruction register and hands it to
// decode with valid/ready. It also handles branch flush, start/restart and
// halt-word detection.
module fetch_sequencer #(
  parameter int                 ADDR_W      = 4,
  parameter int                 INSTR_W     = 8,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF
) (
  input logic                clk,
  input logic                rst_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] ir, ir_n;
  logic [ADDR_W-1:0]  ir_pc, ir_pc_n;
  logic               ir_valid, ir_valid_n;
  logic               running, halted;
  logic               load;

  // Load a new instruction whenever the IR is empty or being drained this cycle.
  // A branch takes precedence over the load.
  assign load = (state == RUN) && (!ir_valid || bus.ir_ready) && !bus.branch_valid;

  // State and datapath registers; running/halted are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      running  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
      running  <= (state_n == RUN) || (state_n == DRAIN);
      halted   <= (state_n == HALTED);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          pc_n    = '0;
        end
      end
      RUN: begin
        if (bus.branch_valid) begin
          pc_n       = bus.branch_target;
          ir_valid_n = 1'b0;
        end else if (load) begin
          ir_n       = bus.imem_instr;
          ir_pc_n    = pc;
          ir_valid_n = 1'b1;
          pc_n       = pc + ADDR_W'(1);   // wraps naturally at 2**ADDR_W
          if (bus.imem_instr == HALT_OPCODE) state_n = DRAIN;
        end else if (ir_valid && bus.ir_ready) begin
          ir_valid_n = 1'b0;
        end
      end
      DRAIN: begin
        // The halt word waits in the IR. A branch abandons the halt.
        if (bus.branch_valid) begin
          pc_n       = bus.branch_target;
          ir_valid_n = 1'b0;
          state_n    = RUN;
        end else if (ir_valid && bus.ir_ready) begin
          ir_valid_n = 1'b0;
          state_n    = HALTED;
        end
      end
      HALTED: begin
        if (bus.start) begin
          state_n    = RUN;
          pc_n       = '0;
          ir_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.pc_sel   = pc;
  assign bus.ir       = ir;
  assign bus.ir_pc    = ir_pc;
  assign bus.ir_valid = ir_valid;
  assign bus.running  = running;
  assign bus.halted   = halted;
  assign bus.state    = state;

endmodule
